// File: rtl/led_matrix_pkg.sv
// Shared encodings, geometry defaults and FM6126 init words for the HUB75 test-pattern driver.
package led_matrix_pkg;

    localparam int unsigned COLS_DEF     = 64;
    localparam int unsigned BITS_DEF     = 4;
    localparam int unsigned BASE_ON_DEF  = 16;
    localparam int unsigned RST_HOLD_DEF = 255;

    localparam int unsigned COL_W   = 6;
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned PLANE_W = 2;
    localparam int unsigned LEVEL_W = 4;
    localparam int unsigned ON_W    = 16;
    localparam int unsigned RST_W   = 8;
    localparam int unsigned RGB_W   = 3;

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_CFG     = 5'd1,
        S_SHIFT   = 5'd2,
        S_LATCH   = 5'd3,
        S_DISPLAY = 5'd4,
        S_NEXT    = 5'd5
    } state_e;

    typedef struct packed {
        logic b;
        logic g;
        logic r;
    } rgb_t;

    localparam logic [15:0] FM6126_REG11 = 16'h7FFF;
    localparam logic [15:0] FM6126_REG12 = 16'h0040;

endpackage

// File: rtl/led_test_pattern.sv
// Combinational test-pattern pixel: R=x/4, G=y/4, B=R^G, one BCM bit plane selected.
module led_test_pattern
    import led_matrix_pkg::*;
(
    input  logic [COL_W-1:0]   x_i,
    input  logic [COL_W-1:0]   y_i,
    input  logic [PLANE_W-1:0] plane_i,
    output rgb_t               rgb_c_o
);

    logic [LEVEL_W-1:0] r_lvl;
    logic [LEVEL_W-1:0] g_lvl;
    logic [LEVEL_W-1:0] b_lvl;

    assign r_lvl = x_i[5:2];
    assign g_lvl = y_i[5:2];
    assign b_lvl = r_lvl ^ g_lvl;

    assign rgb_c_o.r = r_lvl[plane_i];
    assign rgb_c_o.g = g_lvl[plane_i];
    assign rgb_c_o.b = b_lvl[plane_i];

endmodule

// File: rtl/led_matrix_test_sim.sv
// HUB75 64x64 driver with built-in BCM test pattern; FM6126_INIT_EN adds FM6126 register init in S_CFG.
module led_matrix_test_sim
    import led_matrix_pkg::*;
#(
    parameter int unsigned COLS     = COLS_DEF,
    parameter int unsigned BITS     = BITS_DEF,
    parameter int unsigned BASE_ON  = BASE_ON_DEF,
    parameter int unsigned RST_HOLD = RST_HOLD_DEF
) (
    input  logic             clk_25mhz,
    input  logic             rst_n,
    output logic             LP_CLK,
    output logic             LATCH,
    output logic             NOE,
    output logic [RGB_W-1:0] RGB0,
    output logic [RGB_W-1:0] RGB1,
    output logic [ROW_W-1:0] ROW
);

    state_e               state_q, state_d;
    logic [RST_W-1:0]     rst_cnt_q;
    logic                 cfg_done_q, cfg_done_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 phase_q, phase_d;
    logic [PLANE_W-1:0]   plane_q, plane_d;
    logic [ON_W-1:0]      on_cnt_q, on_cnt_d;
    logic [ON_W-1:0]      on_len;

    logic                 lp_clk_q, lp_clk_d;
    logic                 latch_q, latch_d;
    logic                 noe_q, noe_d;
    logic [RGB_W-1:0]     rgb0_q, rgb0_d;
    logic [RGB_W-1:0]     rgb1_q, rgb1_d;
    logic [ROW_W-1:0]     row_out_q, row_out_d;

    rgb_t                 pat_top;
    rgb_t                 pat_bot;

`ifdef FM6126_INIT_EN
    logic                 cfg_sel_q, cfg_sel_d;
    logic [15:0]          cfg_word;
    logic                 cfg_bit;
    logic [COL_W-1:0]     cfg_lat_from;
`endif

    led_test_pattern u_pat_top (
        .x_i     (col_q),
        .y_i     ({1'b0, row_q}),
        .plane_i (plane_q),
        .rgb_c_o (pat_top)
    );

    led_test_pattern u_pat_bot (
        .x_i     (col_q),
        .y_i     ({1'b1, row_q}),
        .plane_i (plane_q),
        .rgb_c_o (pat_bot)
    );

    // Reset stretch: counts up after release and saturates at RST_HOLD
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q <= '0;
        end else if (rst_cnt_q != RST_W'(RST_HOLD)) begin
            rst_cnt_q <= rst_cnt_q + RST_W'(1);
        end
    end

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cfg_done_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            phase_q    <= 1'b0;
            plane_q    <= '0;
            on_cnt_q   <= '0;
            lp_clk_q   <= 1'b0;
            latch_q    <= 1'b0;
            noe_q      <= 1'b1;
            rgb0_q     <= '0;
            rgb1_q     <= '0;
            row_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            cfg_done_q <= cfg_done_d;
            row_q      <= row_d;
            col_q      <= col_d;
            phase_q    <= phase_d;
            plane_q    <= plane_d;
            on_cnt_q   <= on_cnt_d;
            lp_clk_q   <= lp_clk_d;
            latch_q    <= latch_d;
            noe_q      <= noe_d;
            rgb0_q     <= rgb0_d;
            rgb1_q     <= rgb1_d;
            row_out_q  <= row_out_d;
        end
    end

`ifdef FM6126_INIT_EN
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            cfg_sel_q <= 1'b0;
        end else begin
            cfg_sel_q <= cfg_sel_d;
        end
    end

    assign cfg_word     = cfg_sel_q ? FM6126_REG12 : FM6126_REG11;
    assign cfg_bit      = cfg_word[4'd15 - col_q[3:0]];
    assign cfg_lat_from = cfg_sel_q ? COL_W'(COLS - 12) : COL_W'(COLS - 11);
`endif

    // Next-state and registered-output decode; outputs appear one cycle after their state
    always_comb begin
        state_d    = state_q;
        cfg_done_d = cfg_done_q;
        row_d      = row_q;
        col_d      = col_q;
        phase_d    = phase_q;
        plane_d    = plane_q;
        on_cnt_d   = on_cnt_q;
        lp_clk_d   = 1'b0;
        latch_d    = 1'b0;
        noe_d      = 1'b1;
        rgb0_d     = rgb0_q;
        rgb1_d     = rgb1_q;
        row_out_d  = row_out_q;
        on_len     = ON_W'(BASE_ON) << plane_q;
`ifdef FM6126_INIT_EN
        cfg_sel_d  = cfg_sel_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (rst_cnt_q == RST_W'(RST_HOLD)) begin
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
`ifdef FM6126_INIT_EN
                lp_clk_d = phase_q;
                latch_d  = (col_q >= cfg_lat_from);
                if (!phase_q) begin
                    rgb0_d  = {RGB_W{cfg_bit}};
                    rgb1_d  = {RGB_W{cfg_bit}};
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d = '0;
                        if (cfg_sel_q) begin
                            cfg_done_d = 1'b1;
                            state_d    = S_SHIFT;
                        end else begin
                            cfg_sel_d = 1'b1;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
`else
                cfg_done_d = 1'b1;
                col_d      = '0;
                phase_d    = 1'b0;
                state_d    = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                lp_clk_d = phase_q;
                if (!phase_q) begin
                    rgb0_d  = pat_top;
                    rgb1_d  = pat_bot;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (col_q == COL_W'(COLS - 1)) begin
                        state_d = S_LATCH;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_LATCH: begin
                latch_d   = 1'b1;
                row_out_d = row_q;
                on_cnt_d  = '0;
                state_d   = S_DISPLAY;
            end
            S_DISPLAY: begin
                noe_d = 1'b0;
                if (on_cnt_q == on_len - ON_W'(1)) begin
                    state_d = S_NEXT;
                end else begin
                    on_cnt_d = on_cnt_q + ON_W'(1);
                end
            end
            S_NEXT: begin
                if (plane_q == PLANE_W'(BITS - 1)) begin
                    plane_d = '0;
                    row_d   = row_q + ROW_W'(1);
                end else begin
                    plane_d = plane_q + PLANE_W'(1);
                end
                col_d   = '0;
                phase_d = 1'b0;
                state_d = S_SHIFT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign LP_CLK = lp_clk_q;
    assign LATCH  = latch_q;
    assign NOE    = noe_q;
    assign RGB0   = rgb0_q;
    assign RGB1   = rgb1_q;
    assign ROW    = row_out_q;

endmodule

// File: tb/tb_led_matrix_test_sim.sv
// Bench for led_matrix_test_sim (FM6126_INIT_EN undefined): per-cycle output model plus random resets.
module tb_led_matrix_test_sim;

    localparam int NCOLS     = 64;
    localparam int NPLANES   = 4;
    localparam int BASE      = 16;
    localparam int NROWS     = 32;
    localparam int SHIFT_CYC = 2 * NCOLS;
    localparam int START     = 258;

    typedef struct {
        logic       lp;
        logic       latch;
        logic       noe;
        logic [2:0] rgb0;
        logic [2:0] rgb1;
        logic [4:0] row;
    } out_t;

    logic       clk;
    logic       rst_n;
    logic       lp_clk;
    logic       latch;
    logic       noe;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
    logic [4:0] row;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    led_matrix_test_sim dut (
        .clk_25mhz (clk),
        .rst_n     (rst_n),
        .LP_CLK    (lp_clk),
        .LATCH     (latch),
        .NOE       (noe),
        .RGB0      (rgb0),
        .RGB1      (rgb1),
        .ROW       (row)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] pat(input int x, input int y, input int p);
        int lr, lg, lb;
        lr = (x >> 2) & 15;
        lg = (y >> 2) & 15;
        lb = lr ^ lg;
        return {1'((lb >> p) & 1), 1'((lg >> p) & 1), 1'((lr >> p) & 1)};
    endfunction

    function automatic out_t reset_out();
        out_t o;
        o.lp = 1'b0; o.latch = 1'b0; o.noe = 1'b1;
        o.rgb0 = 3'd0; o.rgb1 = 3'd0; o.row = 5'd0;
        return o;
    endfunction

    // Expected pins t cycles after the first shift output of the scan
    function automatic out_t model(input int t);
        out_t o;
        int per_row, rr, u, p, len, col;
        per_row = 0;
        for (int q = 0; q < NPLANES; q++) per_row += SHIFT_CYC + 2 + (BASE << q);
        rr = (t / per_row) % NROWS;
        u  = t % per_row;
        p  = 0;
        while (u >= SHIFT_CYC + 2 + (BASE << p)) begin
            u -= SHIFT_CYC + 2 + (BASE << p);
            p++;
        end
        len = BASE << p;
        o = reset_out();
        if (u < SHIFT_CYC) begin
            col    = u / 2;
            o.lp   = 1'(u % 2);
            o.rgb0 = pat(col, rr, p);
            o.rgb1 = pat(col, rr + 32, p);
            if (p != 0)            o.row = 5'(rr);
            else if (t < SHIFT_CYC) o.row = 5'd0;
            else                   o.row = 5'((rr + NROWS - 1) % NROWS);
        end else begin
            o.rgb0  = pat(NCOLS - 1, rr, p);
            o.rgb1  = pat(NCOLS - 1, rr + 32, p);
            o.latch = (u == SHIFT_CYC);
            o.noe   = !(u > SHIFT_CYC && u <= SHIFT_CYC + len);
            o.row   = 5'(rr);
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    // Per-cycle comparison against the model, plus pinned literal expectations
    always @(negedge clk) begin
        out_t e;
        if (!rst_n || cyc < START) e = reset_out();
        else                       e = model(cyc - START);
        check("lp_clk", int'(lp_clk), int'(e.lp));
        check("latch",  int'(latch),  int'(e.latch));
        check("noe",    int'(noe),    int'(e.noe));
        check("rgb0",   int'(rgb0),   int'(e.rgb0));
        check("rgb1",   int'(rgb1),   int'(e.rgb1));
        check("row",    int'(row),    int'(e.row));
        if (rst_n) begin
            if (cyc == START + 628) begin
                check("pin_rgb0_x63_y0_p3", int'(rgb0), 5);
                check("pin_rgb1_x63_y32_p3", int'(rgb1), 3);
            end
            if (cyc == START + 128) begin
                check("pin_first_latch", int'(latch), 1);
                check("pin_first_row", int'(row), 0);
            end
            if (cyc == START + 31 * 760 + 128) check("pin_row31", int'(row), 31);
            if (cyc == START + 24320 + 128) begin
                check("pin_wrap_latch", int'(latch), 1);
                check("pin_wrap_row0", int'(row), 0);
            end
        end
    end

    // Structural monitors: LP_CLK edges per latch, latch width, NOE-low run lengths
    logic prev_lp, prev_latch, prev_noe;
    int   lp_rises, latch_w, noe_run, run_idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_lp = 1'b0; prev_latch = 1'b0; prev_noe = 1'b1;
            lp_rises = 0; latch_w = 0; noe_run = 0; run_idx = 0;
        end else begin
            if (lp_clk && !prev_lp) lp_rises++;
            if (latch) latch_w++;
            if (latch && !prev_latch) begin
                check("lp_rises_per_latch", lp_rises, 64);
                lp_rises = 0;
            end
            if (!latch && prev_latch) begin
                check("latch_width", latch_w, 1);
                latch_w = 0;
            end
            if (!noe) noe_run++;
            if (noe && !prev_noe) begin
                if (run_idx < 4) check("noe_low_width", noe_run, 16 << run_idx);
                run_idx++;
                noe_run = 0;
            end
            prev_lp = lp_clk; prev_latch = latch; prev_noe = noe;
        end
    end

    task automatic apply_reset(input bool_mid);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_noe", int'(noe), 1);
        check("async_rst_row", int'(row), 0);
        check("async_rst_latch", int'(latch), 0);
        check("async_rst_lp", int'(lp_clk), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit seen;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (26000) @(posedge clk);

        // Reset asserted while the panel is lit
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (!noe) seen = 1'b1;
        end
        check("found_display_phase", int'(seen), 1);
        apply_reset(1'b1);
        repeat (1200) @(posedge clk);

        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(6000, 300);
            repeat (n) @(posedge clk);
            apply_reset(1'b0);
        end
        repeat (3000) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_matrix_test_sim.md
# led_matrix_test_sim

HUB75 panel driver with a built-in test-pattern source, used to bring up and simulate the 64×64 LED matrix path before the calculator front end is connected. It generates the shift clock, latch, output-enable, RGB data for two half-panels and a 5-bit row address. Brightness uses binary-coded modulation (BCM) over 4 bit planes. It sits directly on the FPGA pins that drive the panel.

## Interface
- COLS, 64: pixels shifted per row.
- BITS, 4: BCM bit planes per colour.
- BASE_ON, 16: NOE-low cycles for bit plane 0; plane p is lit for BASE_ON<<p cycles.
- RST_HOLD, 255: internal reset-stretch count.
- clk_25mhz  in  1  system clock, 25 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- LP_CLK  out  1  panel shift clock; data is sampled on its rising edge.
- LATCH  out  1  latches the shift register into the column drivers.
- NOE  out  1  output enable, active-low.
- RGB0  out  3  upper-half pixel, {B,G,R}.
- RGB1  out  3  lower-half pixel (row+32), {B,G,R}.
- ROW  out  5  row-pair address.

## Operation
- Reset stretch: rst_counter (8 bit) clears on rst_n low. After release it counts up to RST_HOLD and saturates. The core FSM is held in S_IDLE until the counter saturates.
- State register is 5 bits:
  - S_IDLE=0
  - S_CFG=1
  - S_SHIFT=2
  - S_LATCH=3
  - S_DISPLAY=4
  - S_NEXT=5
  - All other codes go to S_IDLE.
- S_IDLE → S_CFG, entered once the stretch saturates.
- S_CFG: runs the panel init (see Configuration), then sets config_done=1 and goes to S_SHIFT. config_done stays 1 until reset.
- S_SHIFT: for col_counter 0..COLS-1, each column takes 2 cycles.
  - Phase 0: LP_CLK=0 and RGB0/RGB1 are updated.
  - Phase 1: LP_CLK=1.
  - After col 63 phase 1 → S_LATCH.
- S_LATCH: one cycle with LATCH=1 and NOE=1. ROW is updated to row_counter in this cycle. → S_DISPLAY.
- S_DISPLAY: NOE=0 for BASE_ON<<bit_plane cycles, then NOE=1 → S_NEXT.
- S_NEXT: one cycle.
  - bit_plane increments.
  - When it wraps from BITS-1 to 0, row_counter increments (31 wraps to 0).
  - col_counter clears → S_SHIFT.
- Test pattern: y_top=row_counter, y_bot=row_counter+32, x=col_counter, 6-bit values. Per half:
  - R level = x[5:2]
  - G level = y[5:2]
  - B level = x[5:2]^y[5:2]
  - Output bit = level[bit_plane].
- Registers are never X after the stretch; every register has a reset value.

## Timing
- Reset values:
  - LP_CLK=0, LATCH=0, NOE=1, RGB0=RGB1=0, ROW=0.
  - state=S_IDLE, config_done=0.
  - row_counter=0, col_counter=0, bit_plane=0.
- First S_CFG cycle is RST_HOLD+1 cycles after rst_n rises.
- Cycles per row per plane: 128 (shift) + 1 (latch) + BASE_ON<<p (display) + 1 (next).
- With defaults:
  - Per row: 4×130 + 16×15 = 760 cycles.
  - Per frame: 32 rows = 24 320 cycles (~973 µs).
- rst_n low at any time: all outputs go to their reset values asynchronously and the stretch restarts.
- NOE is never low while LATCH=1 or during S_SHIFT.

## Configuration
- FM6126_INIT_EN defined: S_CFG shifts two 64-bit register words, reg 11 = 0x7FFF pattern and reg 12 = 0x0040 pattern.
  - Each word is shifted at the LP_CLK rate with identical data on all six RGB lines.
  - LATCH is held high for the final 11 (reg 11) or 12 (reg 12) columns.
  - Duration is 2×128 cycles, then config_done=1.
- Undefined: S_CFG lasts exactly one cycle and sets config_done=1.

## Structure
- Shared package led_matrix_pkg holds:
  - state encodings
  - COLS, BITS, BASE_ON defaults
  - FM6126 register words
- One sub-module, led_test_pattern: combinational (x, y, bit_plane) → {B,G,R} bit, instantiated twice for the upper and lower halves.

## Test plan
- Release rst_n at t=0 → at cycle 256, rst_n=1, state≠X, config_done=1 (macro off). No X on any output after cycle 300.
- Macro off, cycle 512 → state=S_SHIFT or later, row_counter=0, col_counter advancing.
- Count LP_CLK rising edges between LATCH pulses → exactly 64. LATCH width is 1 cycle. NOE=1 throughout shifting.
- NOE-low widths across one row → 16, 32, 64, 128 cycles in plane order 0..3. ROW then advances 0→1.
- Run 2 ms → ROW wraps 31→0 after 24 320 cycles per frame. At x=63, y=0, plane 3: RGB0={B=1,G=0,R=1}.
- Assert rst_n low mid-S_DISPLAY → NOE=1 and ROW=0 immediately. After release, state stays S_IDLE for 255 cycles.
